// File: rtl/bar_graph_pwm_wb.sv
// bar_graph_pwm_wb: Wishbone slave driving an 8-LED bar graph with per-LED
// 8-bit PWM. It also has a level-meter mode, where the bottom LEVEL LEDs share
// the brightness of DUTY[0].
// Duty values go to the PWM comparators only through shadow registers. The
// shadows load on a PWM period boundary, so a period is never cut short.
module bar_graph_pwm_wb #(
    parameter int          ADDR_WIDTH     = 8,
    parameter int          DATA_WIDTH     = 16,
    parameter logic [15:0] PRESCALE_RESET = 16'd0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] wbs_address,
    input  logic [DATA_WIDTH-1:0] wbs_writedata,
    output logic [DATA_WIDTH-1:0] wbs_readdata,
    input  logic                  wbs_write,
    input  logic                  wbs_strobe,
    input  logic                  wbs_cycle,
    output logic                  wbs_ack,
    output logic [7:0]            bar_graph
);

    localparam logic [3:0]            A_CTRL     = 4'h0;
    localparam logic [3:0]            A_LEVEL    = 4'h1;
    localparam logic [3:0]            A_PRESCALE = 4'hA;
    localparam logic [3:0]            A_STATUS   = 4'hB;
    localparam logic [DATA_WIDTH-1:0] LEVEL_MAX  = DATA_WIDTH'(8);

    logic                  r_ack;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [7:0]            r_bar;
    logic [1:0]            r_ctrl;
    logic [3:0]            r_level;
    logic [7:0]            r_duty   [8];
    logic [7:0]            r_shadow [8];
    logic [15:0]           r_prescale;
    logic [15:0]           r_pre_cnt;
    logic [7:0]            r_pwm_cnt;
    logic                  r_flag;

    logic                  w_req;
    logic                  w_wr;
    logic                  w_rd;
    logic [3:0]            w_addr;
    logic                  w_tick;
    logic                  w_boundary;
    logic [7:0]            w_eff    [8];
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_unused_addr;

    // The ack register masks the request for one cycle. A held strobe
    // therefore gets at most one transfer every two cycles.
    assign w_req         = wbs_cycle & wbs_strobe & ~r_ack;
    assign w_wr          = w_req & wbs_write;
    assign w_rd          = w_req & ~wbs_write;
    assign w_addr        = wbs_address[3:0];
    assign w_tick        = (r_pre_cnt == r_prescale);
    assign w_boundary    = w_tick & (r_pwm_cnt == 8'hFF);
    assign w_unused_addr = ^wbs_address;

    assign wbs_ack      = r_ack;
    assign wbs_readdata = r_rdata;
    assign bar_graph    = r_bar;

    // Effective duty per LED: the raw duty, or the shared meter brightness
    // for LEDs below LEVEL.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w_eff[i] = r_duty[i];
            if (r_ctrl[1]) begin
                w_eff[i] = (4'(i) < r_level) ? r_duty[0] : 8'h00;
            end
        end
    end

    // Read mux; unused data bits read as zero.
    always_comb begin
        w_rdata = '0;
        case (w_addr)
            A_CTRL:     w_rdata[1:0]  = r_ctrl;
            A_LEVEL:    w_rdata[3:0]  = r_level;
            A_PRESCALE: w_rdata[15:0] = r_prescale;
            A_STATUS:   w_rdata[8:0]  = {r_flag, r_pwm_cnt};
            default: begin
                for (int i = 0; i < 8; i++) begin
                    if (w_addr == 4'(i + 2)) w_rdata[7:0] = r_duty[i];
                end
            end
        endcase
    end

    // Bus handshake: single-cycle ack; read data is captured with the ack.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ack   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack <= w_req;
            if (w_rd) r_rdata <= w_rdata;
        end
    end

    // Register writes. A LEVEL above the LED count saturates to 8.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ctrl     <= 2'b00;
            r_level    <= 4'd0;
            r_prescale <= PRESCALE_RESET;
            for (int i = 0; i < 8; i++) r_duty[i] <= 8'h00;
        end else if (w_wr) begin
            case (w_addr)
                A_CTRL:     r_ctrl     <= wbs_writedata[1:0];
                A_LEVEL:    r_level    <= (wbs_writedata > LEVEL_MAX) ? 4'd8 : wbs_writedata[3:0];
                A_PRESCALE: r_prescale <= wbs_writedata[15:0];
                default: begin
                    for (int i = 0; i < 8; i++) begin
                        if (w_addr == 4'(i + 2)) r_duty[i] <= wbs_writedata[7:0];
                    end
                end
            endcase
        end
    end

    // Prescaler counts 0..PRESCALE. A new PRESCALE value restarts it from 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pre_cnt <= 16'd0;
        end else if ((w_wr && (w_addr == A_PRESCALE)) || w_tick) begin
            r_pre_cnt <= 16'd0;
        end else begin
            r_pre_cnt <= r_pre_cnt + 16'd1;
        end
    end

    // PWM phase counter advances once per prescaler tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pwm_cnt <= 8'd0;
        end else if (w_tick) begin
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
        end
    end

    // Shadow duties load only at a period boundary. A write on that same
    // edge is not visible yet, so it takes effect one period later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) r_shadow[i] <= 8'h00;
        end else if (w_boundary) begin
            for (int i = 0; i < 8; i++) r_shadow[i] <= w_eff[i];
        end
    end

    // Boundary flag: set by a boundary, cleared by a STATUS read; set wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flag <= 1'b0;
        end else if (w_boundary) begin
            r_flag <= 1'b1;
        end else if (w_rd && (w_addr == A_STATUS)) begin
            r_flag <= 1'b0;
        end
    end

    // LED drive: duty 0xFF is fully on; otherwise on while the phase < duty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bar <= 8'h00;
        end else begin
            for (int i = 0; i < 8; i++) begin
                r_bar[i] <= r_ctrl[0] & ((r_shadow[i] == 8'hFF) | (r_pwm_cnt < r_shadow[i]));
            end
        end
    end

endmodule
